// File: rtl/fpga_ram_pkg.sv
// Shared constants for the FPGA two-port RAM model: write-mode encodings and clear FSM states.
package fpga_ram_pkg;

    localparam int WMODE_NO_CHANGE   = 0;
    localparam int WMODE_WRITE_FIRST = 1;
    localparam int WMODE_READ_FIRST  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/fpga_ram_rdport.sv
// Per-port read path: write-mode data select, optional output register, and valid generation.
// Latency 1 (P_OUT_REG=0) or 2 (P_OUT_REG=1); no backpressure, one valid per accepted read.
module fpga_ram_rdport
    import fpga_ram_pkg::*;
#(
    parameter int P_DATA_WIDTH = 20,
    parameter int P_OUT_REG    = 0,
    parameter int P_WMODE      = WMODE_NO_CHANGE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_en,
    input  logic                    wr_en,
    input  logic [P_DATA_WIDTH-1:0] old_word,
    input  logic [P_DATA_WIDTH-1:0] new_word,
    output logic [P_DATA_WIDTH-1:0] dr,
    output logic                    vld
);

    logic                    fire;
    logic [P_DATA_WIDTH-1:0] sel_word;
    logic [P_DATA_WIDTH-1:0] s1_dat;
    logic                    s1_vld;

    // A combined write+read in NO_CHANGE mode suppresses the read entirely.
    always_comb begin
        fire     = rd_en && !(wr_en && (P_WMODE == WMODE_NO_CHANGE));
        sel_word = (wr_en && (P_WMODE == WMODE_WRITE_FIRST)) ? new_word : old_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_dat <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= fire;
            if (fire) begin
                s1_dat <= sel_word;
            end
        end
    end

    generate
        if (P_OUT_REG != 0) begin : g_out_reg
            logic [P_DATA_WIDTH-1:0] s2_dat;
            logic                    s2_vld;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_dat <= '0;
                    s2_vld <= 1'b0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) begin
                        s2_dat <= s1_dat;
                    end
                end
            end

            assign dr  = s2_dat;
            assign vld = s2_vld;
        end else begin : g_no_out_reg
            assign dr  = s1_dat;
            assign vld = s1_vld;
        end
    endgenerate

endmodule

// File: rtl/fpga_ram_2p_sync.sv
// Single-clock true-dual-port RAM with bit masks, write modes, collision merge and a clear sweep.
// Read latency 1 or 2 (P_OUT_REG); no backpressure, ports are dropped while the clear sweep runs.
module fpga_ram_2p_sync
    import fpga_ram_pkg::*;
#(
    parameter int P_DATA_WIDTH = 20,
    parameter int P_ADDR_WIDTH = 9,
    parameter int P_COUNT      = 2**P_ADDR_WIDTH,
    parameter int P_OUT_REG    = 0,
    parameter int P_A_WMODE    = WMODE_NO_CHANGE,
    parameter int P_B_WMODE    = WMODE_NO_CHANGE
) (
    input  logic                    CLK_I,
    input  logic                    RSTN_I,
    input  logic                    CLR_I,
    output logic                    BUSY_O,
    output logic                    COLL_O,
    input  logic                    A_CS_I,
    input  logic                    A_WE_I,
    input  logic                    A_RE_I,
    input  logic [P_ADDR_WIDTH-1:0] A_ADDR_I,
    input  logic [P_DATA_WIDTH-1:0] A_DW_I,
    input  logic [P_DATA_WIDTH-1:0] A_BM_I,
    output logic [P_DATA_WIDTH-1:0] A_DR_O,
    output logic                    A_VLD_O,
    input  logic                    B_CS_I,
    input  logic                    B_WE_I,
    input  logic                    B_RE_I,
    input  logic [P_ADDR_WIDTH-1:0] B_ADDR_I,
    input  logic [P_DATA_WIDTH-1:0] B_DW_I,
    input  logic [P_DATA_WIDTH-1:0] B_BM_I,
    output logic [P_DATA_WIDTH-1:0] B_DR_O,
    output logic                    B_VLD_O
);

    logic [P_DATA_WIDTH-1:0] mem [P_COUNT];

    clr_state_t              state_q, state_d;
    logic [P_ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                    busy;

    logic a_acc, b_acc, a_in, b_in, a_wr, b_wr, same_addr, both_wr, coll_d;
    logic [P_DATA_WIDTH-1:0] a_old, b_old, a_new, b_new, both_word;

    assign busy   = (state_q == ST_CLEAR);
    assign BUSY_O = busy;

    always_comb begin
        a_acc     = A_CS_I && !busy;
        b_acc     = B_CS_I && !busy;
        a_in      = 32'(A_ADDR_I) < P_COUNT;
        b_in      = 32'(B_ADDR_I) < P_COUNT;
        a_wr      = a_acc && A_WE_I && a_in;
        b_wr      = b_acc && B_WE_I && b_in;
        same_addr = (A_ADDR_I == B_ADDR_I);
        a_old     = a_in ? mem[A_ADDR_I] : '0;
        b_old     = b_in ? mem[B_ADDR_I] : '0;
        a_new     = a_in ? ((a_old & ~A_BM_I) | (A_DW_I & A_BM_I)) : '0;
        b_new     = b_in ? ((b_old & ~B_BM_I) | (B_DW_I & B_BM_I)) : '0;
        both_wr   = a_wr && b_wr && same_addr;
        // Port A owns every bit it masks; B only fills bits A left untouched.
        both_word = (a_old & ~A_BM_I & ~B_BM_I) | (B_DW_I & B_BM_I & ~A_BM_I) | (A_DW_I & A_BM_I);
        coll_d    = a_acc && b_acc && a_in && same_addr &&
                    ((A_WE_I && B_WE_I) || (A_WE_I && B_RE_I) || (B_WE_I && A_RE_I));
    end

    // Memory has no reset so contents survive RSTN_I.
    always_ff @(posedge CLK_I) begin
        if (busy) begin
            mem[clr_addr_q] <= '0;
        end else if (both_wr) begin
            mem[A_ADDR_I] <= both_word;
        end else begin
            if (a_wr) mem[A_ADDR_I] <= a_new;
            if (b_wr) mem[B_ADDR_I] <= b_new;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (CLR_I) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_q == P_ADDR_WIDTH'(P_COUNT - 1)) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            COLL_O     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            COLL_O     <= coll_d;
        end
    end

    fpga_ram_rdport #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_OUT_REG    (P_OUT_REG),
        .P_WMODE      (P_A_WMODE)
    ) u_rdport_a (
        .clk      (CLK_I),
        .rst_n    (RSTN_I),
        .rd_en    (a_acc && A_RE_I),
        .wr_en    (a_acc && A_WE_I),
        .old_word (a_old),
        .new_word (a_new),
        .dr       (A_DR_O),
        .vld      (A_VLD_O)
    );

    fpga_ram_rdport #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_OUT_REG    (P_OUT_REG),
        .P_WMODE      (P_B_WMODE)
    ) u_rdport_b (
        .clk      (CLK_I),
        .rst_n    (RSTN_I),
        .rd_en    (b_acc && B_RE_I),
        .wr_en    (b_acc && B_WE_I),
        .old_word (b_old),
        .new_word (b_new),
        .dr       (B_DR_O),
        .vld      (B_VLD_O)
    );

endmodule

// File: tb/tb_fpga_ram_2p_sync.sv
// Directed bench: one DUT at latency 1 (A WRITE_FIRST, B READ_FIRST), one at latency 2 (both NO_CHANGE), shared inputs.
module tb_fpga_ram_2p_sync;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clr = 1'b0;
    logic        a_cs, a_we, a_re, b_cs, b_we, b_re;
    logic [8:0]  a_addr, b_addr;
    logic [19:0] a_dw, a_bm, b_dw, b_bm;

    logic        busy, coll, a_vld, b_vld;
    logic [19:0] a_dr, b_dr;
    logic        busy2, coll2, a_vld2, b_vld2;
    logic [19:0] a_dr2, b_dr2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fpga_ram_2p_sync #(
        .P_DATA_WIDTH(20), .P_ADDR_WIDTH(9), .P_COUNT(512),
        .P_OUT_REG(0), .P_A_WMODE(1), .P_B_WMODE(2)
    ) dut (
        .CLK_I(clk), .RSTN_I(rstn), .CLR_I(clr), .BUSY_O(busy), .COLL_O(coll),
        .A_CS_I(a_cs), .A_WE_I(a_we), .A_RE_I(a_re), .A_ADDR_I(a_addr),
        .A_DW_I(a_dw), .A_BM_I(a_bm), .A_DR_O(a_dr), .A_VLD_O(a_vld),
        .B_CS_I(b_cs), .B_WE_I(b_we), .B_RE_I(b_re), .B_ADDR_I(b_addr),
        .B_DW_I(b_dw), .B_BM_I(b_bm), .B_DR_O(b_dr), .B_VLD_O(b_vld)
    );

    fpga_ram_2p_sync #(
        .P_DATA_WIDTH(20), .P_ADDR_WIDTH(9), .P_COUNT(512),
        .P_OUT_REG(1), .P_A_WMODE(0), .P_B_WMODE(0)
    ) dut2 (
        .CLK_I(clk), .RSTN_I(rstn), .CLR_I(clr), .BUSY_O(busy2), .COLL_O(coll2),
        .A_CS_I(a_cs), .A_WE_I(a_we), .A_RE_I(a_re), .A_ADDR_I(a_addr),
        .A_DW_I(a_dw), .A_BM_I(a_bm), .A_DR_O(a_dr2), .A_VLD_O(a_vld2),
        .B_CS_I(b_cs), .B_WE_I(b_we), .B_RE_I(b_re), .B_ADDR_I(b_addr),
        .B_DW_I(b_dw), .B_BM_I(b_bm), .B_DR_O(b_dr2), .B_VLD_O(b_vld2)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        a_cs = 0; a_we = 0; a_re = 0; b_cs = 0; b_we = 0; b_re = 0; clr = 0;
    endtask

    task automatic a_write(input logic [8:0] ad, input logic [19:0] d, input logic [19:0] m);
        a_cs = 1; a_we = 1; a_re = 0; a_addr = ad; a_dw = d; a_bm = m;
    endtask

    task automatic b_write(input logic [8:0] ad, input logic [19:0] d, input logic [19:0] m);
        b_cs = 1; b_we = 1; b_re = 0; b_addr = ad; b_dw = d; b_bm = m;
    endtask

    task automatic a_read(input logic [8:0] ad);
        a_cs = 1; a_we = 0; a_re = 1; a_addr = ad;
    endtask

    task automatic b_read(input logic [8:0] ad);
        b_cs = 1; b_we = 0; b_re = 1; b_addr = ad;
    endtask

    task automatic fill_all();
        for (int i = 0; i < 256; i++) begin
            a_write(9'(2*i), 20'h3C3C3, 20'hFFFFF);
            b_write(9'(2*i+1), 20'h3C3C3, 20'hFFFFF);
            tick();
        end
        idle();
    endtask

    task automatic test_reset();
        n_chk++; if (busy !== 1'b0 || busy2 !== 1'b0) $display("FAIL reset_busy: got %b/%b want 0", busy, busy2); else n_pass++;
        n_chk++; if (coll !== 1'b0 || coll2 !== 1'b0) $display("FAIL reset_coll: got %b/%b want 0", coll, coll2); else n_pass++;
        n_chk++; if (a_dr !== 20'h0 || b_dr !== 20'h0 || a_dr2 !== 20'h0 || b_dr2 !== 20'h0)
            $display("FAIL reset_dr: got %h %h %h %h want 0", a_dr, b_dr, a_dr2, b_dr2); else n_pass++;
        n_chk++; if (a_vld !== 1'b0 || b_vld !== 1'b0 || a_vld2 !== 1'b0 || b_vld2 !== 1'b0)
            $display("FAIL reset_vld: got %b%b%b%b want 0000", a_vld, b_vld, a_vld2, b_vld2); else n_pass++;
    endtask

    task automatic test_basic();
        a_write(5, 20'h12345, 20'hFFFFF); tick();
        idle(); b_read(5); tick();
        n_chk++; if (b_dr !== 20'h12345 || b_vld !== 1'b1) $display("FAIL basic_lat1: got %h vld %b want 12345 vld 1", b_dr, b_vld); else n_pass++;
        n_chk++; if (b_vld2 !== 1'b0) $display("FAIL basic_lat2_early: got vld %b want 0", b_vld2); else n_pass++;
        idle(); tick();
        n_chk++; if (b_dr2 !== 20'h12345 || b_vld2 !== 1'b1) $display("FAIL basic_lat2: got %h vld %b want 12345 vld 1", b_dr2, b_vld2); else n_pass++;
        n_chk++; if (b_dr !== 20'h12345 || b_vld !== 1'b0) $display("FAIL basic_hold: got %h vld %b want 12345 vld 0", b_dr, b_vld); else n_pass++;
    endtask

    task automatic test_mask();
        a_write(7, 20'hFFFFF, 20'hFFFFF); tick();
        a_write(7, 20'h00000, 20'h000F0); tick();
        idle(); b_read(7); tick();
        n_chk++; if (b_dr !== 20'hFFF0F) $display("FAIL mask: got %h want fff0f", b_dr); else n_pass++;
        idle(); tick();
    endtask

    task automatic test_wmode();
        a_write(3, 20'hAAAAA, 20'hFFFFF); tick();
        idle(); a_read(3); tick();
        n_chk++; if (a_dr !== 20'hAAAAA || a_vld !== 1'b1) $display("FAIL wmode_pre: got %h vld %b want aaaaa vld 1", a_dr, a_vld); else n_pass++;
        idle(); tick();
        a_cs = 1; a_we = 1; a_re = 1; a_addr = 3; a_dw = 20'h55555; a_bm = 20'hFFFFF; tick();
        n_chk++; if (a_dr !== 20'h55555 || a_vld !== 1'b1) $display("FAIL wmode_write_first: got %h vld %b want 55555 vld 1", a_dr, a_vld); else n_pass++;
        idle(); tick();
        n_chk++; if (a_dr2 !== 20'hAAAAA || a_vld2 !== 1'b0) $display("FAIL wmode_no_change: got %h vld %b want aaaaa vld 0", a_dr2, a_vld2); else n_pass++;
        tick();
        n_chk++; if (a_vld2 !== 1'b0) $display("FAIL wmode_no_change_late: got vld %b want 0", a_vld2); else n_pass++;
        b_write(4, 20'h11111, 20'hFFFFF); tick();
        b_cs = 1; b_we = 1; b_re = 1; b_addr = 4; b_dw = 20'h22222; b_bm = 20'hFFFFF; tick();
        n_chk++; if (b_dr !== 20'h11111 || b_vld !== 1'b1) $display("FAIL wmode_read_first: got %h vld %b want 11111 vld 1", b_dr, b_vld); else n_pass++;
        idle(); b_read(4); a_read(3); tick();
        n_chk++; if (b_dr !== 20'h22222 || a_dr !== 20'h55555) $display("FAIL wmode_commit: got %h %h want 22222 55555", b_dr, a_dr); else n_pass++;
        idle(); tick();
    endtask

    task automatic test_collision();
        a_write(9, 20'h0000F, 20'h000FF); b_write(9, 20'hFFF00, 20'hFFFFF); tick();
        n_chk++; if (coll !== 1'b1 || coll2 !== 1'b1) $display("FAIL coll_ww_flag: got %b/%b want 1", coll, coll2); else n_pass++;
        idle(); b_read(9); tick();
        n_chk++; if (coll !== 1'b0) $display("FAIL coll_pulse_width: got %b want 0", coll); else n_pass++;
        n_chk++; if (b_dr !== 20'hFFF0F) $display("FAIL coll_ww_merge: got %h want fff0f", b_dr); else n_pass++;
        a_write(9, 20'h12121, 20'hFFFFF); b_read(9); tick();
        n_chk++; if (b_dr !== 20'hFFF0F || b_vld !== 1'b1) $display("FAIL coll_wr_old: got %h vld %b want fff0f vld 1", b_dr, b_vld); else n_pass++;
        n_chk++; if (coll !== 1'b1) $display("FAIL coll_wr_flag: got %b want 1", coll); else n_pass++;
        idle(); a_read(9); b_read(9); tick();
        n_chk++; if (b_dr !== 20'h12121 || a_dr !== 20'h12121) $display("FAIL coll_rr_data: got %h %h want 12121", a_dr, b_dr); else n_pass++;
        n_chk++; if (coll !== 1'b0) $display("FAIL coll_rr_flag: got %b want 0", coll); else n_pass++;
        idle(); tick();
    endtask

    task automatic test_clear();
        int cnt;
        int bad;
        fill_all();
        clr = 1; b_read(0); tick();
        n_chk++; if (busy !== 1'b1 || busy2 !== 1'b1) $display("FAIL clear_busy_start: got %b/%b want 1", busy, busy2); else n_pass++;
        n_chk++; if (b_dr !== 20'h3C3C3 || b_vld !== 1'b1) $display("FAIL clear_sample_cycle_read: got %h vld %b want 3c3c3 vld 1", b_dr, b_vld); else n_pass++;
        cnt = 0;
        bad = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            cnt++;
            b_read(1);
            a_write(2, 20'h0F0F0, 20'hFFFFF);
            clr = (cnt == 10);
            tick();
            if (b_vld !== 1'b0 || a_vld !== 1'b0 || coll !== 1'b0) bad++;
        end
        idle();
        n_chk++; if (cnt != 512) $display("FAIL clear_busy_len: got %0d cycles want 512", cnt); else n_pass++;
        n_chk++; if (bad != 0) $display("FAIL clear_dropped_access: got %0d valid/coll cycles want 0", bad); else n_pass++;
        a_read(0); b_read(255); tick();
        n_chk++; if (a_dr !== 20'h0 || b_dr !== 20'h0 || a_vld !== 1'b1) $display("FAIL clear_zero_0_255: got %h %h want 0 0", a_dr, b_dr); else n_pass++;
        idle(); b_read(511); a_read(2); tick();
        n_chk++; if (b_dr !== 20'h0 || a_dr !== 20'h0) $display("FAIL clear_zero_511_2: got %h %h want 0 0", b_dr, a_dr); else n_pass++;
        idle(); tick();
    endtask

    task automatic test_reset_mid_clear();
        fill_all();
        a_read(10); tick();
        n_chk++; if (a_dr !== 20'h3C3C3) $display("FAIL midclr_preload: got %h want 3c3c3", a_dr); else n_pass++;
        idle(); clr = 1; tick();
        clr = 0;
        repeat (100) tick();
        n_chk++; if (busy !== 1'b1) $display("FAIL midclr_busy_before: got %b want 1", busy); else n_pass++;
        rstn = 0;
        #1;
        n_chk++; if (busy !== 1'b0 || busy2 !== 1'b0) $display("FAIL midclr_busy_reset: got %b/%b want 0", busy, busy2); else n_pass++;
        n_chk++; if (a_dr !== 20'h0 || a_dr2 !== 20'h0 || b_dr !== 20'h0 || a_vld !== 1'b0 || coll !== 1'b0)
            $display("FAIL midclr_outputs_reset: got %h %h %h vld %b coll %b want 0", a_dr, a_dr2, b_dr, a_vld, coll); else n_pass++;
        tick(); tick();
        rstn = 1;
        tick();
        n_chk++; if (busy !== 1'b0) $display("FAIL midclr_busy_after: got %b want 0", busy); else n_pass++;
        a_read(50); b_read(300); tick();
        n_chk++; if (a_dr !== 20'h0) $display("FAIL midclr_addr50: got %h want 0", a_dr); else n_pass++;
        n_chk++; if (b_dr !== 20'h3C3C3) $display("FAIL midclr_addr300: got %h want 3c3c3", b_dr); else n_pass++;
        a_read(99); b_read(100); tick();
        n_chk++; if (a_dr !== 20'h0 || b_dr !== 20'h3C3C3) $display("FAIL midclr_boundary: got %h %h want 0 3c3c3", a_dr, b_dr); else n_pass++;
        idle(); tick();
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, checks %0d passed %0d", n_chk, n_pass);
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        a_addr = 0; b_addr = 0; a_dw = 0; b_dw = 0; a_bm = 0; b_bm = 0;
        rstn = 0;
        tick(); tick();
        test_reset();
        rstn = 1;
        tick();
        test_basic();
        test_mask();
        test_wmode();
        test_collision();
        test_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fpga_ram_2p_sync.md
Name: fpga_ram_2p_sync

Overview:
- Single-clock, parametrised true-dual-port synchronous RAM model for the FPGA RAM simulation library.
- Successor to the fixed 512x20 two-port behavioural core; width, depth and output pipelining are generic.
- Adds per-port write modes, defined same-address collision resolution, a collision flag, and a hardware clear sequencer.
- Sits under the block-RAM primitive wrappers; both ports are driven from the same fabric clock.

Parameters:
- P_DATA_WIDTH, 20, word width in bits.
- P_ADDR_WIDTH, 9, address width.
- P_COUNT, 2**P_ADDR_WIDTH, number of words. Must be <= 2**P_ADDR_WIDTH.
- P_OUT_REG, 0, 0 gives read latency 1; 1 adds an output register for read latency 2.
- P_A_WMODE, 0, port A write mode: 0 NO_CHANGE, 1 WRITE_FIRST, 2 READ_FIRST.
- P_B_WMODE, 0, port B write mode, same encoding as P_A_WMODE.

Ports:
- CLK_I  in  1  single clock for both ports.
- RSTN_I  in  1  reset, asynchronous, active-low. Clears control and output registers only, not memory.
- CLR_I  in  1  one-cycle request to zero the whole array.
- BUSY_O  out  1  clear sequencer active.
- COLL_O  out  1  one-cycle pulse: same-address collision detected.
- A_CS_I / B_CS_I  in  1  port select.
- A_WE_I / B_WE_I  in  1  write enable.
- A_RE_I / B_RE_I  in  1  read enable.
- A_ADDR_I / B_ADDR_I  in  P_ADDR_WIDTH  word address.
- A_DW_I / B_DW_I  in  P_DATA_WIDTH  write data.
- A_BM_I / B_BM_I  in  P_DATA_WIDTH  bit mask; 1 means the bit is written.
- A_DR_O / B_DR_O  out  P_DATA_WIDTH  read data.
- A_VLD_O / B_VLD_O  out  1  read data valid, aligned with DR_O.

Behaviour:
- Reset values: DR_O=0, VLD_O=0, BUSY_O=0, COLL_O=0, FSM=IDLE. Memory contents are retained through reset.
- Port access occurs when CS=1 and BUSY_O=0. Port inputs are ignored when CS=0.
- Write: mem[addr] = (mem & ~BM) | (DW & BM), committed at the clock edge.
- Addresses >= P_COUNT: writes are dropped; reads return 0 with VLD_O=1.
- Read latency: data on cycle N+1 (P_OUT_REG=0) or N+2 (P_OUT_REG=1). VLD_O is asserted in that same cycle for exactly one cycle per read.
- Without a read, DR_O holds its last value and VLD_O=0.
- Same port, WE=1 and RE=1 in one cycle, by write mode:
  - NO_CHANGE: DR_O holds and VLD_O=0.
  - WRITE_FIRST: DR_O returns the merged new word, VLD_O=1.
  - READ_FIRST: DR_O returns the pre-write word, VLD_O=1.
- Collision cases (both ports CS=1, same address):
  - Both write: bits with A_BM=1 take A_DW. Bits with only B_BM=1 take B_DW. COLL_O=1 on the next cycle.
  - One port writes, the other reads: the reading port returns the pre-write word. COLL_O=1 on the next cycle.
  - Both read: normal reads, no COLL_O.
- COLL_O is a single pipeline stage and is not delayed by P_OUT_REG.
- Clear FSM, IDLE -> CLEAR -> IDLE:
  - CLR_I=1 in IDLE moves the FSM to CLEAR. BUSY_O=1 from the next cycle.
  - In CLEAR, one word is zeroed per cycle, addresses 0..P_COUNT-1. BUSY_O stays high for exactly P_COUNT cycles, then the FSM returns to IDLE.
  - In the cycle CLR_I is sampled, the port access still executes. During CLEAR, port accesses are dropped with VLD_O=0 and COLL_O=0.
  - CLR_I during CLEAR is ignored; the sweep does not restart.
  - Reads issued just before the clear still complete their pipeline. The output register stage is unaffected by BUSY_O.
- Reset mid-clear: the FSM returns to IDLE, BUSY_O=0, the clear address resets to 0, and memory is left partially cleared. This is legal, not an error.

Decomposition:
- Package fpga_ram_pkg holds:
  - write-mode constants WMODE_NO_CHANGE=0, WMODE_WRITE_FIRST=1, WMODE_READ_FIRST=2;
  - FSM state constants ST_IDLE and ST_CLEAR.
- Sub-module fpga_ram_rdport is instantiated once per port. It contains the write-mode mux, the optional output register and VLD generation.
- The array, collision merge and clear FSM live in the top level.

Test Plan:
- Basic write/read: A writes addr 5 = 0x12345 with BM=0xFFFFF. B reads addr 5 the next cycle. Result: B_DR_O=0x12345 and B_VLD_O=1 one cycle later; with P_OUT_REG=1, two cycles later.
- Bit mask: addr 7 holds 0xFFFFF. A writes DW=0x00000 with BM=0x000F0. A read of addr 7 returns 0xFFF0F.
- Write modes: addr 3 holds 0xAAAAA. A does WE=RE=1 with DW=0x55555. Result: A_DR_O=0x55555 for WRITE_FIRST, 0xAAAAA for READ_FIRST, and unchanged with VLD_O=0 for NO_CHANGE.
- Collision: A and B both write addr 9 (A: DW=0x0000F, BM=0x000FF; B: DW=0xFFF00, BM=0xFFFFF). Result: mem[9]=0xFFF0F and COLL_O pulses for one cycle. Separately, A writes addr 9 while B reads addr 9: B gets the old word and COLL_O=1.
- Clear: fill all 512 words with 0x3C3C3 and pulse CLR_I. BUSY_O is high for exactly 512 cycles and port reads during that time give VLD_O=0. Afterwards, reads of addrs 0, 255 and 511 return 0.
- Reset mid-clear: RSTN_I low at clear cycle 100 forces BUSY_O=0 and all outputs to 0. After reset, addr 50 reads 0 and addr 300 reads 0x3C3C3.
